// File: rtl/cpu_prefetch_unit.sv
// cpu_prefetch_unit: byte-wide instruction fetch sequencer feeding a prefetch queue.
// Reads one byte per ADDR/WAIT/CAPTURE pass, assembles little-endian words and queues them
// for decode. Redirect flushes everything and restarts at a new PC.
// Optional build macro CPU_FETCH_READY_EN adds a mem_ready input that can stretch WAIT.
module cpu_prefetch_unit #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       WORD_BYTES  = 2,
    parameter int unsigned       QUEUE_DEPTH = 4,
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_r,
    input  logic [7:0]                   mem_data,
`ifdef CPU_FETCH_READY_EN
    input  logic                         mem_ready,
`endif
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         fetch_halt,
    output logic                         word_valid,
    output logic [8*WORD_BYTES-1:0]      word,
    output logic [ADDR_W-1:0]            word_pc,
    input  logic                         word_ready,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count
);
    localparam int unsigned      WORD_W   = 8 * WORD_BYTES;
    localparam int unsigned      IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned      PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StWait, StCapture} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] start_pc_q, start_pc_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic [WORD_W-1:0] part_q, part_d;

    logic [WORD_W-1:0] q_word [QUEUE_DEPTH];
    logic [ADDR_W-1:0] q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              rdy, pop, push, last_byte, wait_done;
    logic [WORD_W-1:0] push_word;
    logic [ADDR_W-1:0] push_pc;

`ifdef CPU_FETCH_READY_EN
    assign rdy = mem_ready;
`else
    assign rdy = 1'b1;
`endif

    assign word_valid  = (count_q != '0);
    // A redirect discards any pop requested in the same cycle.
    assign pop         = word_valid & word_ready & ~redirect;
    assign word        = q_word[rd_ptr_q];
    assign word_pc     = q_pc[rd_ptr_q];
    assign queue_count = count_q;
    // fetch_pc only moves in CAPTURE, so it doubles as the held read address.
    assign mem_addr    = fetch_pc_q;
    assign last_byte   = (byte_idx_q == LAST_IDX);
    assign wait_done   = (int'(wait_cnt_q) + 1) >= int'(WAIT_STATES);
    assign push_pc     = (byte_idx_q == '0) ? fetch_pc_q : start_pc_q;

    // Merge the byte being captured into its lane of the partial word.
    always_comb begin
        push_word = part_q;
        push_word[8*byte_idx_q +: 8] = mem_data;
    end

    // Fetch sequencer: next state, read strobe and queue push request.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        start_pc_d = start_pc_q;
        byte_idx_d = byte_idx_q;
        wait_cnt_d = wait_cnt_q;
        part_d     = part_q;
        mem_r      = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fetch_halt && (int'(count_q) - int'(pop) < int'(QUEUE_DEPTH))) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                mem_r      = 1'b1;
                wait_cnt_d = '0;
                if (WAIT_STATES == 0 && rdy) state_d = StCapture;
                else                         state_d = StWait;
            end
            StWait: begin
                mem_r = 1'b1;
                if (wait_done) begin
                    if (rdy) state_d = StCapture;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            StCapture: begin
                mem_r      = 1'b1;
                part_d     = push_word;
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                if (byte_idx_q == '0) start_pc_d = fetch_pc_q;
                if (last_byte) begin
                    push       = 1'b1;
                    byte_idx_d = '0;
                    // Next word only if a slot remains after this push and any pop.
                    if (!fetch_halt &&
                        (int'(count_q) + 1 - int'(pop) < int'(QUEUE_DEPTH))) begin
                        state_d = StAddr;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    byte_idx_d = byte_idx_q + IDX_W'(1);
                    state_d    = StAddr;
                end
            end
            default: state_d = StIdle;
        endcase
        if (redirect) begin
            state_d    = fetch_halt ? StIdle : StAddr;
            fetch_pc_d = redirect_pc;
            byte_idx_d = '0;
            wait_cnt_d = '0;
            push       = 1'b0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            start_pc_q <= RESET_PC;
            byte_idx_q <= '0;
            wait_cnt_q <= '0;
            part_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            start_pc_q <= start_pc_d;
            byte_idx_q <= byte_idx_d;
            wait_cnt_q <= wait_cnt_d;
            part_q     <= part_d;
        end
    end

    // Prefetch queue pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
        end
    end

    // Queue storage; cleared on reset so the idle head reads as zero at RESET_PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                q_word[i] <= '0;
                q_pc[i]   <= RESET_PC;
            end
        end else if (push) begin
            q_word[wr_ptr_q] <= push_word;
            q_pc[wr_ptr_q]   <= push_pc;
        end
    end

endmodule

// File: tb/tb_cpu_prefetch_unit.sv
// tb_cpu_prefetch_unit: directed scenarios followed by randomized traffic, all compared against a
// word-level reference: a FIFO of expected words plus a per-word fetch timer.
module tb_cpu_prefetch_unit;
    localparam int unsigned AW  = 16;
    localparam int unsigned WB  = 2;
    localparam int unsigned QD  = 4;
    localparam int unsigned WS  = 1;
    localparam logic [15:0] RPC = 16'h0000;
    localparam int          BYTE_CYC = 2 + WS;
    localparam int          WORD_CYC = WB * BYTE_CYC;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   mem_addr;
    logic          mem_r;
    logic [7:0]    mem_data;
    logic          redirect;
    logic [15:0]   redirect_pc;
    logic          fetch_halt;
    logic          word_valid;
    logic [15:0]   word;
    logic [15:0]   word_pc;
    logic          word_ready;
    logic [2:0]    queue_count;

    logic [7:0]    mem [65536];
    assign mem_data = mem[mem_addr];

    cpu_prefetch_unit #(
        .ADDR_W     (AW),
        .WORD_BYTES (WB),
        .QUEUE_DEPTH(QD),
        .WAIT_STATES(WS),
        .RESET_PC   (RPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_r      (mem_r),
        .mem_data   (mem_data),
`ifdef CPU_FETCH_READY_EN
        .mem_ready  (1'b1),
`endif
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_halt (fetch_halt),
        .word_valid (word_valid),
        .word       (word),
        .word_pc    (word_pc),
        .word_ready (word_ready),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [15:0] exp_word [$];
    logic [15:0] exp_pc   [$];
    bit          busy;
    int          rem;
    logic [15:0] cur_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_word.delete();
        exp_pc.delete();
        busy   = 1'b0;
        rem    = 0;
        cur_pc = RPC;
    endtask

    // One clock cycle: compare outputs with the model, drive inputs, advance the model.
    task automatic step(input logic rst, input logic rdy, input logic redir,
                        input logic [15:0] rpc, input logic halt);
        logic [15:0] exp_addr;
        logic [15:0] w;
        logic [15:0] a;
        bit          do_pop;
        exp_addr = busy ? cur_pc + 16'((WORD_CYC - rem) / BYTE_CYC) : cur_pc;
        check("word_valid", {31'b0, word_valid}, {31'b0, exp_word.size() != 0});
        check("queue_count", {29'b0, queue_count}, exp_word.size());
        check("mem_r", {31'b0, mem_r}, {31'b0, busy});
        check("mem_addr", {16'b0, mem_addr}, {16'b0, exp_addr});
        if (exp_word.size() != 0) begin
            check("word", {16'b0, word}, {16'b0, exp_word[0]});
            check("word_pc", {16'b0, word_pc}, {16'b0, exp_pc[0]});
        end
        reset       = rst;
        word_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        fetch_halt  = halt;
        do_pop = !rst && !redir && rdy && (exp_word.size() != 0);
        if (rst) begin
            model_reset();
        end else if (redir) begin
            exp_word.delete();
            exp_pc.delete();
            cur_pc = rpc;
            busy   = !halt;
            rem    = WORD_CYC;
        end else begin
            if (do_pop) begin
                void'(exp_word.pop_front());
                void'(exp_pc.pop_front());
            end
            if (busy) begin
                rem--;
                if (rem == 0) begin
                    for (int i = 0; i < int'(WB); i++) begin
                        a = cur_pc + 16'(i);
                        w[8*i +: 8] = mem[a];
                    end
                    exp_word.push_back(w);
                    exp_pc.push_back(cur_pc);
                    cur_pc = cur_pc + 16'(WB);
                    busy   = !halt && (exp_word.size() < QD);
                    rem    = WORD_CYC;
                end
            end else if (!halt && exp_word.size() < QD) begin
                busy = 1'b1;
                rem  = WORD_CYC;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic halt_r;
        int   rdy_pct;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[16'hFFFF] = 8'hAA;
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; fetch_halt = 1'b0; word_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check("rst_word", {16'b0, word}, 32'h0);
        check("rst_word_pc", {16'b0, word_pc}, {16'b0, RPC});
        check("rst_mem_addr", {16'b0, mem_addr}, {16'b0, RPC});
        check("rst_mem_r", {31'b0, mem_r}, 32'h0);

        // First words after reset release.
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("t1_mem_r_e1", {31'b0, mem_r}, 32'h1);
        run(5, 1'b0);
        check("t1_valid_e6", {31'b0, word_valid}, 32'h0);
        run(1, 1'b0);
        check("t1_valid_e7", {31'b0, word_valid}, 32'h1);
        check("t1_word0", {16'b0, word}, 32'h3412);
        check("t1_pc0", {16'b0, word_pc}, 32'h0);
        run(5, 1'b0);
        check("t1_count_e12", {29'b0, queue_count}, 32'h1);
        run(1, 1'b0);
        check("t1_count_e13", {29'b0, queue_count}, 32'h2);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("t1_word1", {16'b0, word}, 32'h7856);
        check("t1_pc1", {16'b0, word_pc}, 32'h2);

        // Fill, then a single pop refetches exactly one word.
        run(40, 1'b0);
        check("t2_full", {29'b0, queue_count}, 32'h4);
        check("t2_idle", {31'b0, mem_r}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("t2_after_pop", {29'b0, queue_count}, 32'h3);
        check("t2_resume", {31'b0, mem_r}, 32'h1);
        run(5, 1'b0);
        check("t2_pending", {29'b0, queue_count}, 32'h3);
        run(1, 1'b0);
        check("t2_refill", {29'b0, queue_count}, 32'h4);
        run(3, 1'b0);
        check("t2_idle_again", {31'b0, mem_r}, 32'h0);

        // Redirect while byte 1 of a word is in WAIT.
        step(1'b0, 1'b0, 1'b1, 16'h0200, 1'b0);
        run(10, 1'b0);
        check("t3_pre_count", {29'b0, queue_count}, 32'h1);
        step(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
        check("t3_valid", {31'b0, word_valid}, 32'h0);
        check("t3_count", {29'b0, queue_count}, 32'h0);
        check("t3_mem_addr", {16'b0, mem_addr}, 32'h0100);
        run(6, 1'b0);
        check("t3_first_pc", {16'b0, word_pc}, 32'h0100);

        // Word straddling the address wrap.
        mem[0] = 8'hBB;
        step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        run(6, 1'b0);
        check("t4_word", {16'b0, word}, 32'hBBAA);
        check("t4_pc", {16'b0, word_pc}, 32'hFFFF);
        run(6, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("t4_next_pc", {16'b0, word_pc}, 32'h0001);

        // Continuous draining from a full queue.
        run(40, 1'b0);
        run(60, 1'b1);

        // Randomized traffic.
        halt_r  = 1'b0;
        rdy_pct = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) rdy_pct = int'($urandom_range(0, 100));
            if ($urandom_range(0, 15) == 0) halt_r = ~halt_r;
            step(($urandom_range(0, 399) == 0),
                 (int'($urandom_range(0, 99)) < rdy_pct),
                 ($urandom_range(0, 49) == 0),
                 16'($urandom),
                 halt_r);
        end
        run(20, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
